// File: rtl/bcd_stopwatch4.sv
// bcd_stopwatch4: 4-digit BCD stopwatch (SS.ss) with edge-detected StartStop/Lap/Clear, registered 7-seg control outputs
module bcd_stopwatch4 #(
  parameter int TICK_DIV = 10
) (
  input  logic       C1K,
  input  logic       RST,
  input  logic       StartStop,
  input  logic       Lap,
  input  logic       Clear,
  output logic [3:0] ValA,
  output logic [3:0] ValB,
  output logic [3:0] ValC,
  output logic [3:0] ValD,
  output logic [6:0] CharA,
  output logic [6:0] CharB,
  output logic [6:0] CharC,
  output logic [6:0] CharD,
  output logic [3:0] Cntrl,
  output logic [3:0] Brank,
  output logic [3:0] DPI,
  output logic       Running
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  typedef enum logic [2:0] {IDLE, RUN, STOP, LAP, OVF} state_t;
  state_t st, st_n;
  logic [15:0] cnt, cnt_n, lap_r, lap_n, disp_n;
  logic [PW-1:0] pre, pre_n;
  logic ss_q, lp_q, cl_q, ss_e, lp_e, cl_e, cnting, tick;
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i+:4] == 4'd9) r[4*i+:4] = 4'd0;
        else begin
          r[4*i+:4] = r[4*i+:4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction
  always_comb begin
    ss_e = StartStop & ~ss_q;
    lp_e = Lap & ~lp_q;
    cl_e = Clear & ~cl_q;
    cnting = st == RUN || st == LAP;
    tick = cnting && pre == PMAX;
    st_n = st;
    cnt_n = cnt;
    lap_n = lap_r;
    pre_n = pre;
    if (cl_e) begin
      st_n = IDLE;
      cnt_n = '0;
      lap_n = '0;
      pre_n = '0;
    end else begin
      pre_n = cnting ? (tick ? '0 : pre + 1'b1) : pre;
      cnt_n = tick && cnt != 16'h9999 ? bcd_inc(cnt) : cnt;
      case (st)
        IDLE: st_n = ss_e ? RUN : IDLE;
        RUN: begin
          st_n = ss_e ? STOP : lp_e ? LAP : RUN;
          lap_n = !ss_e && lp_e ? cnt : lap_r;
        end
        STOP: st_n = ss_e ? RUN : STOP;
        LAP: st_n = ss_e ? STOP : lp_e ? RUN : LAP;
        default: st_n = OVF;
      endcase
      if (tick && cnt == 16'h9999) begin
        st_n = OVF;
        pre_n = '0;
      end
    end
    disp_n = st_n == LAP ? lap_n : cnt_n;
  end
  always_ff @(posedge C1K) begin
    if (RST) begin
      st <= IDLE;
      cnt <= '0;
      lap_r <= '0;
      pre <= '0;
      ss_q <= 1'b0;
      lp_q <= 1'b0;
      cl_q <= 1'b0;
      {ValA, ValB, ValC, ValD} <= '0;
      Cntrl <= 4'b0000;
      Brank <= 4'b1000;
      DPI <= 4'b1011;
      Running <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      lap_r <= lap_n;
      pre <= pre_n;
      ss_q <= StartStop;
      lp_q <= Lap;
      cl_q <= Clear;
      {ValA, ValB, ValC, ValD} <= disp_n;
      Cntrl <= st_n == OVF ? 4'b1111 : 4'b0000;
      Brank <= st_n == OVF ? 4'b0000 : {disp_n[15:12] == 4'd0, 3'b000};
      DPI <= st_n == OVF ? 4'b1111 : 4'b1011;
      Running <= st_n == RUN || st_n == LAP;
    end
  end
  assign CharA = 7'b1111110;
  assign CharB = 7'b1111110;
  assign CharC = 7'b1111110;
  assign CharD = 7'b1111110;
endmodule

// File: tb/tb_bcd_stopwatch4.sv
// tb_bcd_stopwatch4: directed self-checking bench for bcd_stopwatch4 with TICK_DIV=2
module tb_bcd_stopwatch4;
  logic C1K = 1'b0, RST = 1'b0, StartStop = 1'b0, Lap = 1'b0, Clear = 1'b0;
  logic [3:0] ValA, ValB, ValC, ValD, Cntrl, Brank, DPI;
  logic [6:0] CharA, CharB, CharC, CharD;
  logic Running;
  logic [15:0] disp;
  logic [15:0] held;
  int n_chk = 0;
  int n_fail = 0;
  assign disp = {ValA, ValB, ValC, ValD};
  bcd_stopwatch4 #(.TICK_DIV(2)) dut (
    .C1K(C1K), .RST(RST), .StartStop(StartStop), .Lap(Lap), .Clear(Clear),
    .ValA(ValA), .ValB(ValB), .ValC(ValC), .ValD(ValD),
    .CharA(CharA), .CharB(CharB), .CharC(CharC), .CharD(CharD),
    .Cntrl(Cntrl), .Brank(Brank), .DPI(DPI), .Running(Running)
  );
  always #5 C1K = ~C1K;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge C1K);
      #1;
    end
  endtask
  task automatic pulse_ss();
    StartStop = 1'b1;
    step(1);
    StartStop = 1'b0;
  endtask
  task automatic pulse_lap();
    Lap = 1'b1;
    step(1);
    Lap = 1'b0;
  endtask
  task automatic pulse_clr();
    Clear = 1'b1;
    step(1);
    Clear = 1'b0;
  endtask
  task automatic test_reset();
    RST = 1'b1;
    step(2);
    RST = 1'b0;
    n_chk++;
    if ({disp, Cntrl, Brank, DPI, Running} !== {16'h0000, 4'b0000, 4'b1000, 4'b1011, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: disp=%h cntrl=%b brank=%b dpi=%b run=%b want 0000 0000 1000 1011 0", disp, Cntrl, Brank, DPI, Running);
    end
    n_chk++;
    if ({CharA, CharB, CharC, CharD} !== {4{7'b1111110}}) begin
      n_fail++;
      $display("FAIL reset_char: got %b %b %b %b want 1111110 each", CharA, CharB, CharC, CharD);
    end
  endtask
  task automatic test_run_stop();
    pulse_ss();
    step(246);
    n_chk++;
    if ({disp, Brank, Running} !== {16'h0123, 4'b1000, 1'b1}) begin
      n_fail++;
      $display("FAIL run_0123: disp=%h brank=%b run=%b want 0123 1000 1", disp, Brank, Running);
    end
    pulse_ss();
    step(50);
    n_chk++;
    if ({disp, Running} !== {16'h0123, 1'b0}) begin
      n_fail++;
      $display("FAIL stop_freeze: disp=%h run=%b want 0123 0", disp, Running);
    end
    pulse_ss();
    step(3);
    n_chk++;
    if ({disp, Running} !== {16'h0125, 1'b1}) begin
      n_fail++;
      $display("FAIL resume: disp=%h run=%b want 0125 1", disp, Running);
    end
  endtask
  task automatic test_lap();
    pulse_clr();
    n_chk++;
    if ({disp, Running} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL lap_clear: disp=%h run=%b want 0000 0", disp, Running);
    end
    pulse_ss();
    step(80);
    n_chk++;
    if (disp !== 16'h0040) begin
      n_fail++;
      $display("FAIL lap_pre: disp=%h want 0040", disp);
    end
    pulse_lap();
    step(69);
    n_chk++;
    if ({disp, Running} !== {16'h0040, 1'b1}) begin
      n_fail++;
      $display("FAIL lap_hold: disp=%h run=%b want 0040 1", disp, Running);
    end
    pulse_lap();
    n_chk++;
    if ({disp, Running} !== {16'h0075, 1'b1}) begin
      n_fail++;
      $display("FAIL lap_release: disp=%h run=%b want 0075 1", disp, Running);
    end
    StartStop = 1'b1;
    step(20);
    n_chk++;
    if ({disp, Running} !== {16'h0076, 1'b0}) begin
      n_fail++;
      $display("FAIL held_stop: disp=%h run=%b want 0076 0", disp, Running);
    end
    StartStop = 1'b0;
    step(5);
    pulse_lap();
    step(5);
    n_chk++;
    if ({disp, Running} !== {16'h0076, 1'b0}) begin
      n_fail++;
      $display("FAIL lap_in_stop: disp=%h run=%b want 0076 0", disp, Running);
    end
  endtask
  task automatic test_overflow();
    pulse_clr();
    pulse_ss();
    step(19996);
    n_chk++;
    if ({disp, Brank, Cntrl} !== {16'h9998, 4'b0000, 4'b0000}) begin
      n_fail++;
      $display("FAIL ovf_9998: disp=%h brank=%b cntrl=%b want 9998 0000 0000", disp, Brank, Cntrl);
    end
    step(2);
    n_chk++;
    if ({disp, Cntrl, Running} !== {16'h9999, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_9999: disp=%h cntrl=%b run=%b want 9999 0000 1", disp, Cntrl, Running);
    end
    step(2);
    n_chk++;
    if ({Cntrl, Brank, DPI, Running} !== {4'b1111, 4'b0000, 4'b1111, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_enter: cntrl=%b brank=%b dpi=%b run=%b want 1111 0000 1111 0", Cntrl, Brank, DPI, Running);
    end
    n_chk++;
    if ({CharA, CharB, CharC, CharD} !== {4{7'b1111110}}) begin
      n_fail++;
      $display("FAIL ovf_char: got %b %b %b %b want 1111110 each", CharA, CharB, CharC, CharD);
    end
    pulse_ss();
    pulse_lap();
    step(10);
    n_chk++;
    if ({Cntrl, DPI, Running} !== {4'b1111, 4'b1111, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_sticky: cntrl=%b dpi=%b run=%b want 1111 1111 0", Cntrl, DPI, Running);
    end
    pulse_clr();
    n_chk++;
    if ({disp, Cntrl, Brank, DPI, Running} !== {16'h0000, 4'b0000, 4'b1000, 4'b1011, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_clear: disp=%h cntrl=%b brank=%b dpi=%b run=%b want 0000 0000 1000 1011 0", disp, Cntrl, Brank, DPI, Running);
    end
  endtask
  task automatic test_back_to_back();
    pulse_ss();
    step(20);
    held = disp;
    StartStop = 1'b1;
    Lap = 1'b1;
    step(1);
    StartStop = 1'b0;
    Lap = 1'b0;
    step(3);
    n_chk++;
    if ({held, disp, Running} !== {16'h0010, 16'h0010, 1'b0}) begin
      n_fail++;
      $display("FAIL ss_lap_same: pre=%h disp=%h run=%b want 0010 0010 0", held, disp, Running);
    end
    pulse_ss();
    step(6);
    Clear = 1'b1;
    StartStop = 1'b1;
    step(1);
    Clear = 1'b0;
    StartStop = 1'b0;
    n_chk++;
    if ({disp, Running} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL clear_ss_same: disp=%h run=%b want 0000 0", disp, Running);
    end
    step(10);
    n_chk++;
    if ({disp, Running} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL clear_idle: disp=%h run=%b want 0000 0", disp, Running);
    end
  endtask
  task automatic test_mid_reset();
    pulse_ss();
    step(2468);
    n_chk++;
    if ({disp, Brank} !== {16'h1234, 4'b0000}) begin
      n_fail++;
      $display("FAIL pre_rst_1234: disp=%h brank=%b want 1234 0000", disp, Brank);
    end
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    n_chk++;
    if ({disp, Cntrl, Brank, DPI, Running} !== {16'h0000, 4'b0000, 4'b1000, 4'b1011, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_rst: disp=%h cntrl=%b brank=%b dpi=%b run=%b want 0000 0000 1000 1011 0", disp, Cntrl, Brank, DPI, Running);
    end
    step(10);
    n_chk++;
    if ({disp, Running} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_idle: disp=%h run=%b want 0000 0", disp, Running);
    end
  endtask
  initial begin
    test_reset();
    test_run_stop();
    test_lap();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
